// File: rtl/adder_sequencer.sv
// Two-requester 16-bit adder that time-shares an external 4-bit adder slice,
// one nibble per cycle, with round-robin arbitration on contention.
module adder_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_cin,
  input  logic [3:0]  add_sum,
  input  logic        add_cout,
  output logic        res_valid,
  output logic [15:0] res_sum,
  output logic        res_cout,
  output logic        res_id,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        id;
  } op_t;

  logic [1:0]  state;
  logic        prio;
  logic [1:0]  nib;
  logic        carry;
  logic [11:0] acc;
  op_t         op;
  logic        gnt1, accept;

  // Readys are gated by rst_n so they drop the instant reset asserts.
  assign gnt1       = req1_valid && (!req0_valid || prio);
  assign req1_ready = rst_n && (state == IDLE) && gnt1;
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !gnt1;
  assign accept     = req0_ready || req1_ready;
  assign busy       = (state != IDLE);
  assign res_valid  = (state == DONE);

  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = op.a[{nib, 2'b00} +: 4];
      add_b   = op.b[{nib, 2'b00} +: 4];
      add_cin = carry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      prio     <= 1'b0;
      nib      <= 2'd0;
      carry    <= 1'b0;
      acc      <= 12'd0;
      op       <= '0;
      res_sum  <= 16'd0;
      res_cout <= 1'b0;
      res_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op.a  <= req1_ready ? req1_a : req0_a;
          op.b  <= req1_ready ? req1_b : req0_b;
          op.id <= req1_ready;
          nib   <= 2'd0;
          carry <= 1'b0;
          state <= RUN;
        end
        RUN: begin
          carry <= add_cout;
          case (nib)
            2'd0: acc[3:0]  <= add_sum;
            2'd1: acc[7:4]  <= add_sum;
            2'd2: acc[11:8] <= add_sum;
            default: begin
              // Publish only when complete so the result outputs hold between ops.
              res_sum  <= {add_sum, acc};
              res_cout <= add_cout;
              res_id   <= op.id;
            end
          endcase
          if (nib == 2'd3) state <= DONE;
          else             nib   <= nib + 2'd1;
        end
        DONE: begin
          prio  <= ~op.id;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adder_sequencer.sv
// Directed + random bench for adder_sequencer; expected results come from plain
// 17-bit addition, with the external 4-bit slice modelled as a combinational adder.
module tb_adder_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid, req0_ready, req1_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        res_valid, res_cout, res_id, busy;
  logic [15:0] res_sum;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] last_sum;
  logic        last_cout, last_id;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  adder_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .res_valid(res_valid), .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_sum"}, res_sum, 0);
    check({tag, "_res_cout"}, res_cout, 0);
    check({tag, "_res_id"}, res_id, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready0"}, req0_ready, 0);
    check({tag, "_ready1"}, req1_ready, 0);
    check({tag, "_add_a"}, add_a, 0);
    check({tag, "_add_b"}, add_b, 0);
    check({tag, "_add_cin"}, add_cin, 0);
  endtask

  // Call just after a rising edge; returns just after the edge that leaves DONE.
  task automatic do_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                       input bit scramble, input bit imm);
    logic [16:0] sum;
    logic [15:0] m;
    int w;
    bit got;
    sum = {1'b0, a} + {1'b0, b};
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; end
    got = 0;
    w = 0;
    while (w < 20 && !got) begin
      @(negedge clk);
      if (w == 0) check("res_valid_pulse", res_valid, 0);
      if (id ? req1_ready : req0_ready) got = 1;
      else w++;
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      if (id) req1_valid = 0; else req0_valid = 0;
      return;
    end
    if (imm) check("imm_grant_wait", w, 0);
    check("other_ready", id ? req0_ready : req1_ready, 0);
    check("busy_idle", busy, 0);
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
    if (scramble) begin
      if (id) begin req1_a = 16'($urandom); req1_b = 16'($urandom); end
      else    begin req0_a = 16'($urandom); req0_b = 16'($urandom); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m = 16'((32'd1 << (4 * k)) - 1);
      check("add_a", add_a, (a >> (4 * k)) & 16'hF);
      check("add_b", add_b, (b >> (4 * k)) & 16'hF);
      check("add_cin", add_cin, ((({1'b0, a & m} + {1'b0, b & m}) >> (4 * k)) & 17'h1));
      check("busy_run", busy, 1);
      check("res_valid_run", res_valid, 0);
      check("hold_sum", res_sum, last_sum);
      check("hold_cout", res_cout, last_cout);
      check("hold_id", res_id, last_id);
      check("ready_run", req0_ready | req1_ready, 0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("res_valid", res_valid, 1);
    check("res_sum", res_sum, sum[15:0]);
    check("res_cout", res_cout, sum[16]);
    check("res_id", res_id, id);
    check("busy_done", busy, 1);
    check("add_a_done", add_a, 0);
    check("add_cin_done", add_cin, 0);
    last_sum = sum[15:0]; last_cout = sum[16]; last_id = id;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    last_sum = 16'd0; last_cout = 1'b0; last_id = 1'b0;
  endtask

  logic [15:0] sweep [8] = '{16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
                             16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};

  initial begin
    int cyc, nres, ngnt, last_res;
    bit exp_gnt, exp_rid;
    rst_n = 0;
    req0_valid = 0; req1_valid = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    model_reset();
    #2 check_zero("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Basic ops and carry ripple through all nibbles
    do_op(0, 16'h1234, 16'h0FFF, 0, 1);
    do_op(1, 16'hFFFF, 16'h0001, 0, 1);

    // Contention from reset: strict alternation, one result every 6 cycles
    rst_n = 0; #1 check_zero("rst2");
    @(posedge clk); #1 rst_n = 1; model_reset();
    req0_valid = 1; req0_a = 16'd1; req0_b = 16'd1;
    req1_valid = 1; req1_a = 16'd2; req1_b = 16'd2;
    nres = 0; ngnt = 0; last_res = 0; exp_gnt = 0; exp_rid = 0;
    for (cyc = 0; cyc < 24; cyc++) begin
      @(negedge clk);
      check("one_ready", req0_ready & req1_ready, 0);
      if (req0_ready | req1_ready) begin
        check("alt_grant", req1_ready, exp_gnt);
        exp_gnt = ~exp_gnt; ngnt++;
      end
      if (res_valid) begin
        check("alt_id", res_id, exp_rid);
        check("alt_sum", res_sum, exp_rid ? 16'd4 : 16'd2);
        if (nres > 0) check("alt_spacing", cyc - last_res, 6);
        exp_rid = ~exp_rid; last_res = cyc; nres++;
      end
    end
    @(posedge clk); #1 req0_valid = 0; req1_valid = 0;
    check("alt_results", nres, 4);
    check("alt_grants", ngnt, 4);
    last_sum = 16'd4; last_cout = 0; last_id = 1;

    // Leave prio pointing at req1, then abort a req1 op mid-RUN
    do_op(0, 16'h0101, 16'h0202, 0, 1);
    req1_valid = 1; req1_a = 16'hABCD; req1_b = 16'h1111;
    @(negedge clk) check("abort_accept", req1_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 0; #1;
    check_zero("async_rst");
    model_reset();
    @(posedge clk); #1 check("no_res_in_rst", res_valid, 0);
    rst_n = 1;
    do_op(0, 16'h0AAA, 16'h0555, 0, 1);
    do_op(1, 16'hABCD, 16'h1111, 0, 1);

    // Operands scrambled right after acceptance
    do_op(0, 16'h8421, 16'h7BDF, 1, 1);
    do_op(1, 16'hC3A5, 16'h5A3C, 1, 1);

    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        do_op(1'((i + j) & 1), sweep[i], sweep[j], 0, 1);

    for (int r = 0; r < 20; r++)
      do_op(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
